// File: rtl/banner_rom_if.sv
// banner_rom_if: pixel-request / pixel-result bundle between the coordinate
// generator (master) and banner_rom (slave).
//   msg        message select (0 WIN, 1 LOSE, 2 GO, 3 READY)
//   mode       0 static, 1 blink, 2 scroll, 3 scroll+blink
//   frame_tick one-cycle pulse per video frame
//   x, y       viewport column / row (row 0 = top)
//   color      12-bit pixel colour, two cycles after x/y
//   offset     current scroll offset
//   visible    current blink phase, 1 = text shown
interface banner_rom_if #(
  parameter int X_W = 6,
  parameter int Y_W = 3
);
  logic [1:0]     msg;
  logic [1:0]     mode;
  logic           frame_tick;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [11:0]    color;
  logic [7:0]     offset;
  logic           visible;

  modport master (
    output msg, mode, frame_tick, x, y,
    input  color, offset, visible
  );

  modport slave (
    input  msg, mode, frame_tick, x, y,
    output color, offset, visible
  );
endinterface

// File: rtl/banner_rom.sv
// banner_rom: text-banner pixel source for the VGA status overlay.
// Holds four messages (WIN, LOSE, GO, READY) over a shared 5x7 font, each
// character occupying a 7-column cell (blank, 5 glyph columns, blank).
// Supports static, blink, scroll and scroll+blink modes advanced by a
// per-frame tick. Pixel path is a fixed 2-stage pipeline, one pixel/cycle.
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous active-high reset
//   bus   banner_rom_if slave: msg/mode/frame_tick/x/y in,
//         color/offset/visible out
module banner_rom #(
  parameter int unsigned X_W           = 6,
  parameter int unsigned Y_W           = 3,
  parameter int unsigned VIEW_W        = 21,
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned SCROLL_FRAMES = 4,
  parameter logic [11:0] FG_COLOR      = 12'hFF0,
  parameter logic [11:0] BG_COLOR      = 12'h000,
  parameter logic [11:0] ERR_COLOR     = 12'hF00
) (
  input logic         clk,
  input logic         rst,
  banner_rom_if.slave bus
);

  // Column arithmetic width: wide enough for x + offset without overflow.
  localparam int unsigned SW = ((X_W > 8) ? X_W : 8) + 1;

  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] SCROLL_LAST = 8'(SCROLL_FRAMES - 1);

  typedef enum logic [3:0] {
    GL_BLANK, GL_W, GL_I, GL_N, GL_L, GL_O, GL_S,
    GL_E, GL_G, GL_R, GL_A, GL_D, GL_Y
  } glyph_t;

  // Message width in columns (7 per character).
  function automatic logic [7:0] msg_cols(input logic [1:0] m);
    logic [7:0] w;
    case (m)
      2'd0:    w = 8'd21;
      2'd1:    w = 8'd28;
      2'd2:    w = 8'd14;
      default: w = 8'd35;
    endcase
    return w;
  endfunction

  function automatic glyph_t msg_glyph(input logic [1:0] m, input logic [2:0] idx);
    glyph_t g;
    g = GL_BLANK;
    case (m)
      2'd0: begin
        case (idx)
          3'd0:    g = GL_W;
          3'd1:    g = GL_I;
          3'd2:    g = GL_N;
          default: g = GL_BLANK;
        endcase
      end
      2'd1: begin
        case (idx)
          3'd0:    g = GL_L;
          3'd1:    g = GL_O;
          3'd2:    g = GL_S;
          3'd3:    g = GL_E;
          default: g = GL_BLANK;
        endcase
      end
      2'd2: begin
        case (idx)
          3'd0:    g = GL_G;
          3'd1:    g = GL_O;
          default: g = GL_BLANK;
        endcase
      end
      default: begin
        case (idx)
          3'd0:    g = GL_R;
          3'd1:    g = GL_E;
          3'd2:    g = GL_A;
          3'd3:    g = GL_D;
          3'd4:    g = GL_Y;
          default: g = GL_BLANK;
        endcase
      end
    endcase
    return g;
  endfunction

  // Row mask of one cell column; cell columns 0 and 6 are spacing.
  function automatic logic [6:0] glyph_col(input glyph_t g, input logic [2:0] col);
    logic [34:0] cols;
    logic [6:0]  mask;
    case (g)
      GL_W:    cols = {7'h3F, 7'h40, 7'h30, 7'h40, 7'h3F};
      GL_I:    cols = {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
      GL_N:    cols = {7'h7F, 7'h02, 7'h04, 7'h08, 7'h7F};
      GL_L:    cols = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
      GL_O:    cols = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
      GL_S:    cols = {7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
      GL_E:    cols = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
      GL_G:    cols = {7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A};
      GL_R:    cols = {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
      GL_A:    cols = {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
      GL_D:    cols = {7'h7F, 7'h41, 7'h41, 7'h41, 7'h3E};
      GL_Y:    cols = {7'h07, 7'h08, 7'h70, 7'h08, 7'h07};
      default: cols = '0;
    endcase
    case (col)
      3'd1:    mask = cols[34:28];
      3'd2:    mask = cols[27:21];
      3'd3:    mask = cols[20:14];
      3'd4:    mask = cols[13:7];
      3'd5:    mask = cols[6:0];
      default: mask = '0;
    endcase
    return mask;
  endfunction

  // ---------------------------------------------------------------------
  // Animation state
  // ---------------------------------------------------------------------
  logic [1:0] r_msg_q;
  logic [1:0] r_mode_q;
  logic [7:0] r_blink_cnt;
  logic [7:0] r_scroll_cnt;
  logic [7:0] r_offset;
  logic       r_visible;

  logic       w_restart;
  logic [7:0] w_offset_max;

  assign w_restart    = (bus.msg != r_msg_q) || (bus.mode != r_mode_q);
  assign w_offset_max = msg_cols(bus.msg) + 8'(VIEW_W) - 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg_q      <= '0;
      r_mode_q     <= '0;
      r_blink_cnt  <= '0;
      r_scroll_cnt <= '0;
      r_offset     <= '0;
      r_visible    <= 1'b1;
    end else begin
      r_msg_q  <= bus.msg;
      r_mode_q <= bus.mode;
      // A message/mode change restarts the animation and swallows any
      // coincident frame tick.
      if (w_restart) begin
        r_blink_cnt  <= '0;
        r_scroll_cnt <= '0;
        r_offset     <= '0;
        r_visible    <= 1'b1;
      end else begin
        if (!bus.mode[0]) begin
          r_blink_cnt <= '0;
          r_visible   <= 1'b1;
        end else if (bus.frame_tick) begin
          if (r_blink_cnt >= BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_visible   <= ~r_visible;
          end else begin
            r_blink_cnt <= r_blink_cnt + 8'd1;
          end
        end

        if (!bus.mode[1]) begin
          r_scroll_cnt <= '0;
          r_offset     <= '0;
        end else if (bus.frame_tick) begin
          if (r_scroll_cnt >= SCROLL_LAST) begin
            r_scroll_cnt <= '0;
            r_offset     <= (r_offset >= w_offset_max) ? '0 : r_offset + 8'd1;
          end else begin
            r_scroll_cnt <= r_scroll_cnt + 8'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pixel stage 1: logical column -> character index / cell column
  // ---------------------------------------------------------------------
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_c;
  logic [2:0]    w_char;
  logic [2:0]    w_cell;
  logic          w_blank;
  logic          w_oor;

  always_comb begin
    w_sum = SW'(bus.x);
    if (bus.mode[1]) begin
      w_sum = SW'(bus.x) + SW'(r_offset);
    end
    w_c = w_sum;
    // Constant divisor per message: exact wrap even on the cycle a message
    // change meets an offset computed for the previous message.
    if (bus.mode[1]) begin
      case (bus.msg)
        2'd0:    w_c = w_sum % SW'(21 + VIEW_W);
        2'd1:    w_c = w_sum % SW'(28 + VIEW_W);
        2'd2:    w_c = w_sum % SW'(14 + VIEW_W);
        default: w_c = w_sum % SW'(35 + VIEW_W);
      endcase
    end
    w_oor   = (SW'(bus.x) >= SW'(VIEW_W));
    w_blank = (w_c >= SW'(msg_cols(bus.msg))) || (32'(bus.y) >= 32'd7);
    w_char  = '0;
    w_cell  = '0;
    if (!w_blank) begin
      w_char = 3'(w_c / SW'(7));
      w_cell = 3'(w_c % SW'(7));
    end
  end

  logic [2:0]  r_s1_char;
  logic [2:0]  r_s1_cell;
  logic [2:0]  r_s1_row;
  logic        r_s1_blank;
  logic        r_s1_oor;
  logic [1:0]  r_s1_msg;
  logic        r_s1_vis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_char  <= '0;
      r_s1_cell  <= '0;
      r_s1_row   <= '0;
      r_s1_blank <= 1'b1;
      r_s1_oor   <= 1'b0;
      r_s1_msg   <= '0;
      r_s1_vis   <= 1'b1;
    end else begin
      r_s1_char  <= w_char;
      r_s1_cell  <= w_cell;
      r_s1_row   <= 3'(bus.y);
      r_s1_blank <= w_blank;
      r_s1_oor   <= w_oor;
      r_s1_msg   <= bus.msg;
      r_s1_vis   <= r_visible;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel stage 2: font lookup and colour select
  // ---------------------------------------------------------------------
  logic [7:0]  w_mask;
  logic        w_lit;
  logic [11:0] w_color;
  logic [11:0] r_color;

  always_comb begin
    w_mask  = {1'b0, glyph_col(msg_glyph(r_s1_msg, r_s1_char), r_s1_cell)};
    w_lit   = w_mask[r_s1_row];
    w_color = BG_COLOR;
    if (r_s1_oor) begin
      w_color = ERR_COLOR;
    end else if (!r_s1_blank && w_lit && r_s1_vis) begin
      w_color = FG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= BG_COLOR;
    end else begin
      r_color <= w_color;
    end
  end

  assign bus.color   = r_color;
  assign bus.offset  = r_offset;
  assign bus.visible = r_visible;

endmodule

// File: tb/tb_banner_rom.sv
// tb_banner_rom: self-checking bench for banner_rom. Directed steps follow
// the feature list, then randomized pixel/tick traffic. Expected values come
// from a behavioural model built from message strings, a font table and
// tick counts since the last animation restart.
module tb_banner_rom;

  localparam int unsigned X_W    = 6;
  localparam int unsigned Y_W    = 3;
  localparam int unsigned VIEW_W = 21;
  localparam int unsigned BF     = 30;
  localparam int unsigned SF     = 4;
  localparam logic [11:0] FG     = 12'hFF0;
  localparam logic [11:0] BG     = 12'h000;
  localparam logic [11:0] ERR    = 12'hF00;

  logic clk = 1'b0;
  logic rst;

  banner_rom_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  banner_rom #(
    .X_W(X_W), .Y_W(Y_W), .VIEW_W(VIEW_W),
    .BLINK_FRAMES(BF), .SCROLL_FRAMES(SF),
    .FG_COLOR(FG), .BG_COLOR(BG), .ERR_COLOR(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  string       msgs[4];
  int          bt;
  int          st;
  logic [1:0]  last_msg;
  logic [1:0]  last_mode;
  logic [11:0] prev_exp;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  function automatic logic [6:0] font_col(input byte ch, input int k);
    logic [6:0] c[5];
    case (ch)
      "W":     c = '{7'h3F, 7'h40, 7'h30, 7'h40, 7'h3F};
      "I":     c = '{7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
      "N":     c = '{7'h7F, 7'h02, 7'h04, 7'h08, 7'h7F};
      "L":     c = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
      "O":     c = '{7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
      "S":     c = '{7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
      "E":     c = '{7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
      "G":     c = '{7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A};
      "R":     c = '{7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
      "A":     c = '{7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
      "D":     c = '{7'h7F, 7'h41, 7'h41, 7'h41, 7'h3E};
      "Y":     c = '{7'h07, 7'h08, 7'h70, 7'h08, 7'h07};
      default: c = '{default: 7'h00};
    endcase
    return c[k];
  endfunction

  function automatic int span(input logic [1:0] m);
    return 7 * msgs[m].len() + VIEW_W;
  endfunction

  // Offset / visibility held by the design, from ticks since restart.
  function automatic int model_offset();
    if (!last_mode[1]) return 0;
    return (st / SF) % span(last_msg);
  endfunction

  function automatic bit model_vis();
    if (!last_mode[0]) return 1'b1;
    return ((bt / BF) % 2) == 0;
  endfunction

  function automatic logic [11:0] model_color(input logic [1:0] m, input logic [1:0] md,
                                              input int x, input int y);
    int         c;
    int         w;
    byte        ch;
    logic [6:0] colmask;
    if (x >= VIEW_W) return ERR;
    w = 7 * msgs[m].len();
    c = md[1] ? (x + model_offset()) % span(m) : x;
    if (y >= 7 || c >= w) return BG;
    if ((c % 7) == 0 || (c % 7) == 6) return BG;
    ch      = msgs[m][c / 7];
    colmask = font_col(ch, (c % 7) - 1);
    if (!colmask[y] || !model_vis()) return BG;
    return FG;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the pixel now presented, advance the model, then
  // check colour (pixel from the previous cycle's prediction), offset and
  // visibility just after the edge.
  task automatic cyc(input bit tick, input string tag);
    logic [11:0] exp_now;
    bus.frame_tick = tick;
    exp_now = rst ? BG : model_color(bus.msg, bus.mode, int'(bus.x), int'(bus.y));
    if (rst) begin
      bt = 0; st = 0; last_msg = 2'd0; last_mode = 2'd0;
    end else begin
      if (bus.msg != last_msg || bus.mode != last_mode) begin
        bt = 0; st = 0;
      end else if (tick) begin
        if (bus.mode[0]) bt++;
        if (bus.mode[1]) st++;
      end
      last_msg  = bus.msg;
      last_mode = bus.mode;
    end
    @(posedge clk);
    #1;
    chk({tag, ":color"},   32'(bus.color),   32'(rst ? BG : prev_exp));
    chk({tag, ":offset"},  32'(bus.offset),  32'(model_offset()));
    chk({tag, ":visible"}, 32'(bus.visible), 32'(model_vis()));
    prev_exp       = exp_now;
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, tag);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    bus.x = X_W'(x);
    bus.y = Y_W'(y);
    cyc(1'b0, tag);
    cyc(1'b0, tag);
    chk({tag, ":const"}, 32'(bus.color), 32'(exp));
  endtask

  initial begin
    msgs     = '{"WIN", "LOSE", "GO", "READY"};
    n_checks = 0; n_pass = 0; n_fail = 0;
    bt = 0; st = 0; last_msg = 2'd0; last_mode = 2'd0; prev_exp = BG;
    rst = 1'b1;
    bus.msg = 2'd0; bus.mode = 2'd0; bus.frame_tick = 1'b0;
    bus.x = '0; bus.y = '0;

    // Reset state
    cyc(1'b0, "rst");
    cyc(1'b0, "rst");
    chk("rst_color", 32'(bus.color), 32'(BG));
    chk("rst_offset", 32'(bus.offset), 32'd0);
    chk("rst_visible", 32'(bus.visible), 32'd1);
    rst = 1'b0;

    // Static WIN
    pix("win_1_0", 1, 0, FG);
    pix("win_1_6", 1, 6, BG);
    pix("win_10_3", 10, 3, FG);
    pix("win_0_3", 0, 3, BG);

    // Static READY: out of viewport, row 7
    bus.msg = 2'd3;
    pix("ready_25_0", 25, 0, ERR);
    pix("ready_20_7", 20, 7, BG);

    // Scroll WIN
    bus.msg = 2'd0; bus.mode = 2'd2;
    cyc(1'b0, "scr_restart");
    ticks(8, "scr8");
    chk("scr8_offset", 32'(bus.offset), 32'd2);
    pix("scr_0_6", 0, 6, FG);
    pix("scr_0_0", 0, 0, BG);
    ticks(160, "scr168");
    chk("scr168_offset", 32'(bus.offset), 32'd0);

    // Blink WIN
    bus.mode = 2'd1;
    cyc(1'b0, "blk_restart");
    ticks(29, "blk29");
    chk("blk29_visible", 32'(bus.visible), 32'd1);
    ticks(1, "blk30");
    chk("blk30_visible", 32'(bus.visible), 32'd0);
    pix("blk_1_0", 1, 0, BG);
    ticks(30, "blk60");
    chk("blk60_visible", 32'(bus.visible), 32'd1);

    // Message change coincident with a frame tick
    bus.mode = 2'd2;
    cyc(1'b0, "chg_restart");
    ticks(20, "chg20");
    chk("chg20_offset", 32'(bus.offset), 32'd5);
    bus.msg = 2'd2;
    cyc(1'b1, "chg_tick");
    chk("chg_offset", 32'(bus.offset), 32'd0);
    chk("chg_visible", 32'(bus.visible), 32'd1);
    ticks(3, "chg3");
    chk("chg3_offset", 32'(bus.offset), 32'd0);
    ticks(1, "chg4");
    chk("chg4_offset", 32'(bus.offset), 32'd1);

    // Reset mid-scroll
    bus.msg = 2'd0;
    cyc(1'b0, "mid_restart");
    ticks(68, "mid68");
    chk("mid68_offset", 32'(bus.offset), 32'd17);
    bus.x = X_W'(1); bus.y = Y_W'(0);
    rst = 1'b1;
    cyc(1'b0, "mid_rst");
    chk("mid_rst_offset", 32'(bus.offset), 32'd0);
    chk("mid_rst_visible", 32'(bus.visible), 32'd1);
    chk("mid_rst_color0", 32'(bus.color), 32'(BG));
    rst = 1'b0;
    cyc(1'b0, "mid_rel");
    chk("mid_rst_color1", 32'(bus.color), 32'(BG));
    cyc(1'b0, "mid_pix");
    chk("mid_pix_color", 32'(bus.color), 32'(FG));

    // Randomized traffic
    for (int r = 0; r < 30; r++) begin
      int n;
      bus.msg  = 2'($urandom_range(0, 3));
      bus.mode = 2'($urandom_range(0, 3));
      n = int'($urandom_range(20, 120));
      for (int i = 0; i < n; i++) begin
        bus.x = ($urandom_range(0, 7) == 0) ? X_W'($urandom_range(0, (1 << X_W) - 1))
                                            : X_W'($urandom_range(0, VIEW_W - 1));
        bus.y = Y_W'($urandom_range(0, (1 << Y_W) - 1));
        if ($urandom_range(0, 39) == 0) bus.msg = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) bus.mode = 2'($urandom_range(0, 3));
        cyc($urandom_range(0, 3) != 0, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
